sobel_frame_scheduler: RTL and testbench
========================================

Name: sobel_frame_scheduler

Overview:
Frame-level controller that sequences the Sobel/move engine, which processes one frame from BRAM0 into BRAM1.
- Accepts per-frame commands (pixel count plus Sobel/move select) into a small queue.
- Validates each command, then launches the engine with a single-cycle enable.
- Supervises completion with a watchdog timer.
- Holds each finished BRAM1 result until the downstream consumer releases it, so the single BRAM1 buffer is never overwritten while it is being read.

Parameters:
ADDR_WIDTH, 16, width of the pixel-count/address bus; matches the engine.
IMAGE_WIDTH, 5, frame width in pixels.
IMAGE_HEIGHT, 5, frame height in pixels.
FIFO_DEPTH, 2, command queue depth (power of 2, at least 2).
TIMEOUT_CYCLES, 4096, maximum number of cycles in BUSY before a timeout error.
FRAME_CNT_WIDTH, 16, width of the completed-frame counter.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
cmd_valid  in  1  command offered.
cmd_ready  out  1  command can be accepted.
cmd_num_cnt  in  ADDR_WIDTH  pixel count of the frame in BRAM0.
cmd_run  in  1  1 = Sobel, 0 = move.
eng_en  out  1  engine start pulse.
eng_run  out  1  engine mode.
eng_num_cnt  out  ADDR_WIDTH  engine pixel count.
eng_idle  in  1  engine idle status.
eng_done  in  1  engine done pulse.
res_valid  out  1  BRAM1 holds a finished frame.
res_run  out  1  mode of the held frame.
res_ready  in  1  consumer has finished reading BRAM1.
frame_cnt  out  FRAME_CNT_WIDTH  number of released frames; wraps.
err_reject  out  1  one-cycle pulse: the accepted command was dropped.
err_timeout  out  1  sticky watchdog error.
err_clr  in  1  clears the timeout error.
busy  out  1  state is not IDLE, or the queue is not empty.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM goes to IDLE, queue is flushed, watchdog cleared, frame_cnt=0.
  - All outputs are 0, including cmd_ready; cmd_ready rises in the first cycle after rst drops.
  - A reset mid-frame abandons the frame. The engine is reset from the same source through an inverter (the engine uses active-low reset).
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready.
  - cmd_ready = !full && state!=ERROR && !rst.
  - full is the registered occupancy. There is no pop-bypass: a full queue shows ready=0 even in the cycle it pops.
- Validation at acceptance. Let FRAME_PIXELS = IMAGE_WIDTH*IMAGE_HEIGHT. A command is rejected if any of these hold:
  - num_cnt==0;
  - num_cnt>FRAME_PIXELS;
  - cmd_run==1 and num_cnt!=FRAME_PIXELS.
  A rejected command completes its handshake but is not queued, and err_reject pulses in the cycle after acceptance.
- FSM states: IDLE, LAUNCH, BUSY, HOLD, ERROR.
  - IDLE: queue non-empty && eng_idle -> LAUNCH.
  - LAUNCH: eng_en=1 for exactly this one cycle. eng_run/eng_num_cnt are loaded from the queue head into registers in the cycle of entry and are valid while eng_en=1. The head pops. Next state is BUSY.
  - BUSY: the watchdog increments each cycle from 0.
    - eng_done -> HOLD.
    - Watchdog reaching TIMEOUT_CYCLES-1 with no eng_done -> ERROR.
    - If eng_done and timeout occur in the same cycle, done wins.
  - HOLD: res_valid=1 and res_run = mode of the finished frame. When res_ready: frame_cnt+1 and next state IDLE. A new launch is therefore possible at the earliest 2 cycles after the release.
  - ERROR: err_timeout=1, no launches, cmd_ready=0. On err_clr: queue is flushed, watchdog cleared, next state IDLE.
- eng_run/eng_num_cnt keep the last launched values outside LAUNCH.
- eng_done outside BUSY and res_ready outside HOLD are ignored.
- Latency, empty queue and engine idle: command accepted at cycle N; queue non-empty at N+1; eng_en at N+2.
- Commands are launched in strict acceptance order.
- Queue: simultaneous push and pop keeps occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
- frame_cnt wraps from all-ones to 0.

Decomposition:
- Package sobel_sched_pkg holds:
  - the state encoding localparams (IDLE=0, LAUNCH=1, BUSY=2, HOLD=3, ERROR=4; 3-bit);
  - the command record layout {run, num_cnt}, width ADDR_WIDTH+1;
  - FRAME_PIXELS.
- One sub-module: sobel_cmd_fifo, a synchronous FIFO parameterised by data width and depth, with registered full/empty flags and the same clk/rst.

Test Plan:
- Move command num_cnt=25, run=0, engine idle, accepted at cycle N -> eng_en=1 only at N+2 with eng_num_cnt=25, eng_run=0. Engine done -> res_valid=1, res_run=0. res_ready -> frame_cnt=1, busy=0.
- Three back-to-back Sobel commands (num_cnt=25, run=1) with res_ready held low -> first two accepted, third stalls with cmd_ready=0. After each release the next launch follows in order; frame_cnt ends at 3.
- Rejects: num_cnt=0; num_cnt=26; run=1 with num_cnt=20 -> each handshake completes, err_reject pulses once each, no eng_en.
- Launch, then withhold eng_done -> ERROR after TIMEOUT_CYCLES cycles in BUSY: err_timeout=1, cmd_ready=0. err_clr -> IDLE, queue empty, cmd_ready=1.
- eng_done asserted in the same cycle the watchdog expires -> HOLD, err_timeout stays 0.
- rst asserted in BUSY with 1 command queued -> next cycle all outputs 0, queue empty. After release, cmd_ready=1 and no stale launch occurs.

Source files
------------

// File: rtl/sobel_sched_pkg.sv
// Shared definitions for the Sobel frame scheduler.
//   state_t      : FSM state encoding (IDLE=0, LAUNCH=1, BUSY=2, HOLD=3, ERROR=4).
//   frame_pixels : pixel count of a full frame of the given geometry.
//   FRAME_PIXELS : pixel count of the default 5x5 frame.
// The queued command record is {run, num_cnt}, ADDR_WIDTH+1 bits wide; it is
// declared inside the scheduler because its width follows ADDR_WIDTH.
package sobel_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_BUSY   = 3'd2,
    S_HOLD   = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  function automatic int unsigned frame_pixels(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

  localparam int unsigned FRAME_PIXELS = frame_pixels(5, 5);

endpackage

// File: rtl/sobel_cmd_fifo.sv
// Synchronous command queue with registered full/empty flags.
//   clk, rst : clock and synchronous active-high reset
//   flush    : drop every queued entry (same effect as reset on the pointers)
//   push     : write wdata (ignored while full)
//   pop      : discard the head (ignored while empty)
//   rdata    : current head entry, valid while !empty
//   full     : registered, occupancy == DEPTH
//   empty    : registered, occupancy == 0
module sobel_cmd_fifo #(
  parameter int DATA_WIDTH = 17,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // NOTE: storage is deliberately not reset; the empty flag guards every read,
  // and leaving it unreset lets it map onto plain RAM/flops without reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/sobel_frame_scheduler.sv
// Frame-level controller for the Sobel/move engine (BRAM0 -> BRAM1).
//   cmd_*       : command handshake; num_cnt = frame pixel count, run 1=Sobel/0=move
//   eng_*       : engine start pulse, mode and pixel count; engine idle/done status
//   res_*       : finished frame held in BRAM1 until res_ready releases it
//   frame_cnt   : released frames (wraps)
//   err_reject  : one-cycle pulse after an invalid command completed its handshake
//   err_timeout : sticky watchdog error, cleared by err_clr
//   busy        : FSM not idle or queue not empty
// The engine takes its active-low reset from rst through an inverter, so a reset
// here abandons any frame in flight on both sides.
module sobel_frame_scheduler
  import sobel_sched_pkg::*;
#(
  parameter int ADDR_WIDTH      = 16,
  parameter int IMAGE_WIDTH     = 5,
  parameter int IMAGE_HEIGHT    = 5,
  parameter int FIFO_DEPTH      = 2,
  parameter int TIMEOUT_CYCLES  = 4096,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [ADDR_WIDTH-1:0]      cmd_num_cnt,
  input  logic                       cmd_run,
  output logic                       eng_en,
  output logic                       eng_run,
  output logic [ADDR_WIDTH-1:0]      eng_num_cnt,
  input  logic                       eng_idle,
  input  logic                       eng_done,
  output logic                       res_valid,
  output logic                       res_run,
  input  logic                       res_ready,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt,
  output logic                       err_reject,
  output logic                       err_timeout,
  input  logic                       err_clr,
  output logic                       busy
);

  localparam int unsigned FRAME_PIX = frame_pixels(IMAGE_WIDTH, IMAGE_HEIGHT);
  localparam int          WD_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef struct packed {
    logic                  run;
    logic [ADDR_WIDTH-1:0] num_cnt;
  } cmd_t;

  state_t          state;
  logic [WD_W-1:0] wd;
  cmd_t            cmd_in;
  cmd_t            head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            accept;
  logic            cmd_ok;

  assign cmd_in    = '{run: cmd_run, num_cnt: cmd_num_cnt};
  assign cmd_ready = !fifo_full && (state != S_ERROR) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != S_IDLE) || !fifo_empty;

  // A Sobel pass needs the whole frame; a move may copy any non-empty prefix.
  assign cmd_ok = (cmd_num_cnt != '0)
               && (cmd_num_cnt <= ADDR_WIDTH'(FRAME_PIX))
               && !(cmd_run && (cmd_num_cnt != ADDR_WIDTH'(FRAME_PIX)));

  sobel_cmd_fifo #(
    .DATA_WIDTH ($bits(cmd_t)),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (state == S_ERROR && err_clr),
    .push  (accept && cmd_ok),
    .wdata (cmd_in),
    .pop   (state == S_LAUNCH),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wd          <= '0;
      eng_en      <= 1'b0;
      eng_run     <= 1'b0;
      eng_num_cnt <= '0;
      res_valid   <= 1'b0;
      res_run     <= 1'b0;
      frame_cnt   <= '0;
      err_reject  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_reject <= accept && !cmd_ok;
      eng_en     <= 1'b0;
      case (state)
        S_IDLE: begin
          // Engine parameters are captured on entry so they are stable
          // while eng_en is high and hold afterwards.
          if (!fifo_empty && eng_idle) begin
            state       <= S_LAUNCH;
            eng_en      <= 1'b1;
            eng_run     <= head.run;
            eng_num_cnt <= head.num_cnt;
          end
        end
        S_LAUNCH: begin
          state <= S_BUSY;
          wd    <= '0;
        end
        S_BUSY: begin
          // Done is tested first so it wins over a simultaneous expiry.
          if (eng_done) begin
            state     <= S_HOLD;
            res_valid <= 1'b1;
            res_run   <= eng_run;
          end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
            state       <= S_ERROR;
            err_timeout <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            state     <= S_IDLE;
            res_valid <= 1'b0;
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        S_ERROR: begin
          if (err_clr) begin
            state       <= S_IDLE;
            err_timeout <= 1'b0;
            wd          <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_frame_scheduler.sv
// Directed bench for sobel_frame_scheduler: a table of single commands
// (validation, launch latency, full frame round trip) plus hand-written
// sequences for queue back-pressure, watchdog expiry and mid-frame reset.
module tb_sobel_frame_scheduler;
  import sobel_sched_pkg::*;

  localparam int T = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_num_cnt;
  logic        cmd_run;
  logic        eng_en;
  logic        eng_run;
  logic [15:0] eng_num_cnt;
  logic        eng_idle;
  logic        eng_done;
  logic        res_valid;
  logic        res_run;
  logic        res_ready;
  logic [15:0] frame_cnt;
  logic        err_reject;
  logic        err_timeout;
  logic        err_clr;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] exp_frame_cnt = '0;

  always #5 clk = ~clk;

  sobel_frame_scheduler #(
    .ADDR_WIDTH(16), .IMAGE_WIDTH(5), .IMAGE_HEIGHT(5),
    .FIFO_DEPTH(2), .TIMEOUT_CYCLES(T), .FRAME_CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_num_cnt(cmd_num_cnt), .cmd_run(cmd_run),
    .eng_en(eng_en), .eng_run(eng_run), .eng_num_cnt(eng_num_cnt),
    .eng_idle(eng_idle), .eng_done(eng_done),
    .res_valid(res_valid), .res_run(res_run), .res_ready(res_ready),
    .frame_cnt(frame_cnt), .err_reject(err_reject),
    .err_timeout(err_timeout), .err_clr(err_clr), .busy(busy)
  );

  typedef struct {
    logic [15:0] num;
    logic        run;
    logic        exp_rej;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {24'h0, cmd_ready, eng_en, eng_run, eng_num_cnt, res_valid, res_run,
            frame_cnt, err_reject, err_timeout, busy};
  endfunction

  // Offer one command for one cycle; returns in the cycle after acceptance.
  task automatic send(input logic [15:0] num, input logic run);
    cmd_valid   = 1'b1;
    cmd_num_cnt = num;
    cmd_run     = run;
    check("cmd_ready_on_send", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
  endtask

  // Called in the LAUNCH cycle; completes and releases the frame.
  task automatic finish_frame(input logic exp_run);
    eng_idle = 1'b0;
    step();
    check("eng_en_single_cycle", eng_en, 1'b0);
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    check("res_valid_after_done", res_valid, 1'b1);
    check("res_run", res_run, exp_run);
    step();
    check("res_valid_held", res_valid, 1'b1);
    res_ready = 1'b1;
    eng_idle  = 1'b1;
    step();
    res_ready = 1'b0;
    exp_frame_cnt++;
    check("frame_cnt", frame_cnt, exp_frame_cnt);
    check("res_valid_released", res_valid, 1'b0);
  endtask

  task automatic wait_launch();
    logic found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (eng_en) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("launch_within_budget", found, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    tbl[0] = '{num: 16'd0,     run: 1'b0, exp_rej: 1'b1};
    tbl[1] = '{num: 16'd26,    run: 1'b0, exp_rej: 1'b1};
    tbl[2] = '{num: 16'd20,    run: 1'b1, exp_rej: 1'b1};
    tbl[3] = '{num: 16'd25,    run: 1'b1, exp_rej: 1'b0};
    tbl[4] = '{num: 16'd1,     run: 1'b0, exp_rej: 1'b0};
    tbl[5] = '{num: 16'd24,    run: 1'b0, exp_rej: 1'b0};
    tbl[6] = '{num: 16'd25,    run: 1'b0, exp_rej: 1'b0};
    tbl[7] = '{num: 16'hFFFF,  run: 1'b0, exp_rej: 1'b1};
    tbl[8] = '{num: 16'd26,    run: 1'b1, exp_rej: 1'b1};

    rst = 1'b1; cmd_valid = 1'b0; cmd_num_cnt = '0; cmd_run = 1'b0;
    eng_idle = 1'b1; eng_done = 1'b0; res_ready = 1'b0; err_clr = 1'b0;
    step();
    step();
    check("reset_outputs_zero", all_outs(), 64'h0);
    rst = 1'b0;
    #1;
    check("cmd_ready_after_reset", cmd_ready, 1'b1);
    step();

    // Back-to-back Sobel commands against a depth-2 queue.
    cmd_valid = 1'b1; cmd_num_cnt = 16'd25; cmd_run = 1'b1;
    check("b2b_ready_c1", cmd_ready, 1'b1);
    step();
    check("b2b_ready_c2", cmd_ready, 1'b1);
    step();
    check("b2b_full_stall", cmd_ready, 1'b0);
    check("b2b_launch1", eng_en, 1'b1);
    eng_idle = 1'b0;
    step();
    check("b2b_ready_after_pop", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    check("b2b_full_again", cmd_ready, 1'b0);
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    check("b2b_res_valid", res_valid, 1'b1);
    check("b2b_res_run", res_run, 1'b1);
    step();
    step();
    check("b2b_no_launch_in_hold", eng_en, 1'b0);
    check("b2b_res_still_held", res_valid, 1'b1);
    res_ready = 1'b1; eng_idle = 1'b1;
    step();
    res_ready = 1'b0;
    exp_frame_cnt++;
    check("b2b_frame_cnt1", frame_cnt, exp_frame_cnt);
    check("b2b_no_launch_r1", eng_en, 1'b0);
    step();
    check("b2b_launch_r2", eng_en, 1'b1);
    check("b2b_launch2_run", eng_run, 1'b1);
    finish_frame(1'b1);
    wait_launch();
    check("b2b_launch3_num", eng_num_cnt, 16'd25);
    finish_frame(1'b1);
    check("b2b_frame_cnt_end", frame_cnt, 16'd3);
    check("b2b_idle", busy, 1'b0);

    // Table: validation and single-frame round trips.
    for (int i = 0; i < 9; i++) begin
      send(tbl[i].num, tbl[i].run);
      check($sformatf("tbl%0d_err_reject", i), err_reject, tbl[i].exp_rej);
      if (tbl[i].exp_rej) begin
        check($sformatf("tbl%0d_not_queued", i), busy, 1'b0);
        step();
        check($sformatf("tbl%0d_reject_one_pulse", i), err_reject, 1'b0);
        check($sformatf("tbl%0d_no_launch_a", i), eng_en, 1'b0);
        step();
        check($sformatf("tbl%0d_no_launch_b", i), eng_en, 1'b0);
      end else begin
        check($sformatf("tbl%0d_queued", i), busy, 1'b1);
        check($sformatf("tbl%0d_no_early_launch", i), eng_en, 1'b0);
        step();
        check($sformatf("tbl%0d_launch_n2", i), eng_en, 1'b1);
        check($sformatf("tbl%0d_eng_num", i), eng_num_cnt, tbl[i].num);
        check($sformatf("tbl%0d_eng_run", i), eng_run, tbl[i].run);
        finish_frame(tbl[i].run);
        check($sformatf("tbl%0d_idle_after", i), busy, 1'b0);
      end
    end

    // Watchdog expiry with one command queued behind the stuck frame.
    send(16'd25, 1'b0);
    step();
    check("to_launch", eng_en, 1'b1);
    eng_idle = 1'b0;
    for (int i = 1; i <= T; i++) begin
      step();
      if (i == 1) begin
        cmd_valid = 1'b1; cmd_num_cnt = 16'd25; cmd_run = 1'b0;
      end
      if (i == 2) cmd_valid = 1'b0;
    end
    check("to_last_busy_no_err", err_timeout, 1'b0);
    step();
    check("to_err_timeout", err_timeout, 1'b1);
    check("to_cmd_ready_low", cmd_ready, 1'b0);
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    check("to_done_ignored", res_valid, 1'b0);
    check("to_err_sticky", err_timeout, 1'b1);
    eng_idle = 1'b1;
    step();
    check("to_no_launch_in_error", eng_en, 1'b0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("to_err_cleared", err_timeout, 1'b0);
    check("to_ready_after_clr", cmd_ready, 1'b1);
    check("to_queue_flushed", busy, 1'b0);
    step();
    step();
    check("to_no_stale_launch", eng_en, 1'b0);

    // eng_done in the very cycle the watchdog expires.
    send(16'd25, 1'b0);
    step();
    check("tie_launch", eng_en, 1'b1);
    eng_idle = 1'b0;
    for (int i = 1; i <= T; i++) step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    check("tie_hold", res_valid, 1'b1);
    check("tie_no_timeout", err_timeout, 1'b0);
    res_ready = 1'b1; eng_idle = 1'b1;
    step();
    res_ready = 1'b0;
    exp_frame_cnt++;
    check("tie_frame_cnt", frame_cnt, exp_frame_cnt);

    // Reset while BUSY with one command queued.
    send(16'd25, 1'b0);
    step();
    check("rst_launch", eng_en, 1'b1);
    eng_idle = 1'b0;
    step();
    send(16'd12, 1'b0);
    check("rst_busy_before", busy, 1'b1);
    rst = 1'b1;
    step();
    check("rst_mid_frame_outputs_zero", all_outs(), 64'h0);
    rst = 1'b0;
    eng_idle = 1'b1;
    exp_frame_cnt = '0;
    #1;
    check("rst_ready_after_release", cmd_ready, 1'b1);
    check("rst_queue_empty", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_no_stale_launch", eng_en, 1'b0);
    end
    check("rst_frame_cnt", frame_cnt, exp_frame_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
